orient_trig_arbiter: RTL and testbench

Shares one quadrant-folded sin/cos angle lookup table between two orientation requesters in the ORB descriptor pipeline. Each requester submits a full-circle angle bin (0..99, 25 bins per quadrant). The block arbitrates round-robin and derives the quadrant and in-quadrant index. It drives the external first-quadrant LUT index, applies quadrant sign and swap rules, and returns signed sin/cos tagged with the requester id over a valid/ready pipeline.

---
 rtl/orient_trig_if.sv | 43 ++++
 rtl/orient_trig_arbiter.sv | 155 +++++++++++++++
 tb/tb_orient_trig_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/orient_trig_if.sv
`default_nettype none
// ============================================================================
//  Module   : orient_trig_if
//  Brief    : Request, LUT and result signals of the orientation trig arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface orient_trig_if #(
    parameter int BW_OUT = 11,
    parameter int BW_IN  = 5
);
    logic              req0_valid;
    logic [6:0]        req0_bin;
    logic              req0_ready;
    logic              req1_valid;
    logic [6:0]        req1_bin;
    logic              req1_ready;
    logic [BW_IN-1:0]  lut_index;
    logic [BW_OUT-1:0] lut_sin;
    logic [BW_OUT-1:0] lut_cos;
    logic              out_valid;
    logic              out_ready;
    logic              out_id;
    logic [BW_OUT-1:0] out_sin;
    logic [BW_OUT-1:0] out_cos;
    logic              out_err;

    // Arbiter side: takes requests and LUT data, produces results.
    modport slave (
        input  req0_valid, req0_bin, req1_valid, req1_bin,
        input  lut_sin, lut_cos, out_ready,
        output req0_ready, req1_ready, lut_index,
        output out_valid, out_id, out_sin, out_cos, out_err
    );

    // Environment side: requesters, LUT and result consumer.
    modport master (
        output req0_valid, req0_bin, req1_valid, req1_bin,
        output lut_sin, lut_cos, out_ready,
        input  req0_ready, req1_ready, lut_index,
        input  out_valid, out_id, out_sin, out_cos, out_err
    );
endinterface
`default_nettype wire

// File: rtl/orient_trig_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : orient_trig_arbiter
//  Brief    : Round-robin sharing of a first-quadrant sin/cos LUT between two
//             requesters, with quadrant fold into signed full-circle results.
//  Revision : 1.0 - initial release
// ============================================================================
module orient_trig_arbiter #(
    parameter int BW_OUT = 11,
    parameter int BW_IN  = 5
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    orient_trig_if.slave  bus
);

    logic              last_grant_q, last_grant_d;
    logic              s1_valid_q,   s1_valid_d;
    logic              s1_id_q,      s1_id_d;
    logic              s1_err_q,     s1_err_d;
    logic [1:0]        s1_quad_q,    s1_quad_d;
    logic [BW_IN-1:0]  s1_idx_q,     s1_idx_d;
    logic              s2_valid_q,   s2_valid_d;
    logic              out_id_q,     out_id_d;
    logic              out_err_q,    out_err_d;
    logic [BW_OUT-1:0] out_sin_q,    out_sin_d;
    logic [BW_OUT-1:0] out_cos_q,    out_cos_d;

    logic              grant0, grant1, hs0, hs1, hs;
    logic              s2_load, s1_can_load;
    logic [6:0]        sel_bin;
    logic [6:0]        dec_rem;
    logic [1:0]        dec_quad;
    logic              dec_err;
    logic [BW_OUT-1:0] fold_sin, fold_cos;

    // last_grant_q = 1 means req1 was served last, so req0 wins a tie.
    assign grant0      = bus.req0_valid & (~bus.req1_valid |  last_grant_q);
    assign grant1      = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    assign s2_load     = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign s1_can_load = ~s1_valid_q | s2_load;
    assign hs0         = bus.req0_valid & bus.req0_ready;
    assign hs1         = bus.req1_valid & bus.req1_ready;
    assign hs          = hs0 | hs1;
    assign sel_bin     = grant1 ? bus.req1_bin : bus.req0_bin;

    // Quadrant decode by compare/subtract; illegal bins report index 0.
    always_comb begin
        dec_err  = 1'b0;
        dec_quad = 2'd0;
        dec_rem  = 7'd0;
        if (sel_bin >= 7'd100) begin
            dec_err = 1'b1;
        end else if (sel_bin >= 7'd75) begin
            dec_quad = 2'd3;
            dec_rem  = sel_bin - 7'd75;
        end else if (sel_bin >= 7'd50) begin
            dec_quad = 2'd2;
            dec_rem  = sel_bin - 7'd50;
        end else if (sel_bin >= 7'd25) begin
            dec_quad = 2'd1;
            dec_rem  = sel_bin - 7'd25;
        end else begin
            dec_rem  = sel_bin;
        end
    end

    always_comb begin
        fold_sin = bus.lut_sin;
        fold_cos = bus.lut_cos;
        case (s1_quad_q)
            2'd1: begin fold_sin =  bus.lut_cos; fold_cos = -bus.lut_sin; end
            2'd2: begin fold_sin = -bus.lut_sin; fold_cos = -bus.lut_cos; end
            2'd3: begin fold_sin = -bus.lut_cos; fold_cos =  bus.lut_sin; end
            default: ;
        endcase
        if (s1_err_q) begin
            fold_sin = '0;
            fold_cos = '0;
        end
    end

    always_comb begin
        last_grant_d = hs ? hs1 : last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_err_d     = s1_err_q;
        s1_quad_d    = s1_quad_q;
        s1_idx_d     = s1_idx_q;
        if (hs) begin
            s1_valid_d = 1'b1;
            s1_id_d    = hs1;
            s1_err_d   = dec_err;
            s1_quad_d  = dec_quad;
            s1_idx_d   = BW_IN'(dec_rem);
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        out_id_d   = out_id_q;
        out_err_d  = out_err_q;
        out_sin_d  = out_sin_q;
        out_cos_d  = out_cos_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            out_id_d   = s1_id_q;
            out_err_d  = s1_err_q;
            out_sin_d  = fold_sin;
            out_cos_d  = fold_cos;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_quad_q    <= 2'd0;
            s1_idx_q     <= '0;
            s2_valid_q   <= 1'b0;
            out_id_q     <= 1'b0;
            out_err_q    <= 1'b0;
            out_sin_q    <= '0;
            out_cos_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_err_q     <= s1_err_d;
            s1_quad_q    <= s1_quad_d;
            s1_idx_q     <= s1_idx_d;
            s2_valid_q   <= s2_valid_d;
            out_id_q     <= out_id_d;
            out_err_q    <= out_err_d;
            out_sin_q    <= out_sin_d;
            out_cos_q    <= out_cos_d;
        end
    end

    // Readies drop the instant reset asserts, not just at the next edge.
    assign bus.req0_ready = grant0 & s1_can_load & rst_n;
    assign bus.req1_ready = grant1 & s1_can_load & rst_n;
    assign bus.lut_index  = s1_idx_q;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_id     = out_id_q;
    assign bus.out_err    = out_err_q;
    assign bus.out_sin    = out_sin_q;
    assign bus.out_cos    = out_cos_q;

endmodule
`default_nettype wire

// File: tb/tb_orient_trig_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_orient_trig_arbiter
//  Brief    : Self-checking bench for orient_trig_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_orient_trig_arbiter;
    localparam int BW_OUT = 11;
    localparam int BW_IN  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    orient_trig_if #(.BW_OUT(BW_OUT), .BW_IN(BW_IN)) bus ();

    orient_trig_arbiter #(.BW_OUT(BW_OUT), .BW_IN(BW_IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [10:0] tab_sin(input int r);
        return 11'(r * 40);
    endfunction
    function automatic logic [10:0] tab_cos(input int r);
        return 11'(1000 - r * 40);
    endfunction

    assign bus.lut_sin = tab_sin(int'(bus.lut_index));
    assign bus.lut_cos = tab_cos(int'(bus.lut_index));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result {err, sin, cos} for a full-circle bin from the quadrant rules.
    function automatic logic [22:0] model_out(input int bin);
        int q, r;
        logic [10:0] s, c, os, oc;
        if (bin >= 100) return 23'd0 | (23'd1 << 22);
        q = bin / 25;
        r = bin % 25;
        s = tab_sin(r);
        c = tab_cos(r);
        case (q)
            0:       begin os = s;           oc = c;           end
            1:       begin os = c;           oc = 11'd0 - s;   end
            2:       begin os = 11'd0 - s;   oc = 11'd0 - c;   end
            default: begin os = 11'd0 - c;   oc = s;           end
        endcase
        return {1'b0, os, oc};
    endfunction

    // Reference model: queue of in-flight requests, each visible at output
    // two cycles after acceptance or one cycle after its predecessor leaves.
    int m_bin[$];
    int m_id[$];
    int m_acc[$];
    int head_vis = 0;
    int cyc      = 0;
    bit last_g   = 1'b1;

    always @(negedge clk) begin
        bit vis, room, g0, g1;
        int s1e;
        logic [22:0] e;
        cyc++;
        if (!rst_n) begin
            m_bin.delete(); m_id.delete(); m_acc.delete();
            last_g = 1'b1;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_req0_ready", bus.req0_ready, 0);
            chk("rst_req1_ready", bus.req1_ready, 0);
            chk("rst_lut_index", bus.lut_index, 0);
        end else begin
            vis = (m_bin.size() > 0) && (cyc >= head_vis);
            chk("out_valid", bus.out_valid, vis);
            if (vis) begin
                e = model_out(m_bin[0]);
                chk("out_id", bus.out_id, m_id[0]);
                chk("out_err", bus.out_err, e[22]);
                chk("out_sin", bus.out_sin, e[21:11]);
                chk("out_cos", bus.out_cos, e[10:0]);
            end
            s1e = -1;
            if (vis && m_bin.size() > 1) s1e = 1;
            else if (!vis && m_bin.size() > 0) s1e = 0;
            if (s1e >= 0)
                chk("lut_index", bus.lut_index, (m_bin[s1e] >= 100) ? 0 : m_bin[s1e] % 25);
            room = (m_bin.size() < 2) || bus.out_ready;
            g0 = bus.req0_valid && (!bus.req1_valid || last_g);
            g1 = bus.req1_valid && (!bus.req0_valid || !last_g);
            chk("req0_ready", bus.req0_ready, g0 && room);
            chk("req1_ready", bus.req1_ready, g1 && room);
            if (vis && bus.out_ready) begin
                void'(m_bin.pop_front()); void'(m_id.pop_front()); void'(m_acc.pop_front());
                if (m_bin.size() > 0)
                    head_vis = (m_acc[0] + 2 > cyc + 1) ? m_acc[0] + 2 : cyc + 1;
            end
            if (room && (g0 || g1)) begin
                m_bin.push_back(g1 ? int'(bus.req1_bin) : int'(bus.req0_bin));
                m_id.push_back(g1 ? 1 : 0);
                m_acc.push_back(cyc);
                if (m_bin.size() == 1) head_vis = cyc + 2;
                last_g = g1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int fold_bin[4] = '{0, 37, 50, 99};
        int fold_s[4]   = '{0, 520, 0, 2008};
        int fold_c[4]   = '{1000, 1568, 1048, 960};
        int bp_bin[6]   = '{5, 30, 55, 80, 12, 99};
        int sent;

        bus.req0_valid = 1'b0; bus.req0_bin = 7'd0;
        bus.req1_valid = 1'b0; bus.req1_bin = 7'd0;
        bus.out_ready  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // Quadrant fold, two-cycle latency
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.req0_valid = 1'b1;
            bus.req0_bin   = 7'(fold_bin[i]);
            tick();
            bus.req0_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("fold_valid", bus.out_valid, 1);
            chk("fold_sin", bus.out_sin, fold_s[i]);
            chk("fold_cos", bus.out_cos, fold_c[i]);
            chk("fold_id", bus.out_id, 0);
        end

        // Arbitration from reset: 0,1,0,1
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_bin = 7'd10;
        bus.req1_valid = 1'b1; bus.req1_bin = 7'd60;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                chk("arb_id", bus.out_id, k & 1);
                chk("arb_sin", bus.out_sin, (k & 1) ? 1648 : 400);
                chk("arb_cos", bus.out_cos, (k & 1) ? 1448 : 600);
            end
            if (k == 3) begin
                tick();
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end

        // Back-pressure: out_ready low for cycles 3..8 of a 6-bin stream
        tick(); tick();
        sent = 0;
        for (int t = 0; t < 16; t++) begin
            bus.out_ready  = !(t >= 3 && t <= 8);
            bus.req0_valid = (sent < 6);
            bus.req0_bin   = 7'(bp_bin[sent < 6 ? sent : 5]);
            @(negedge clk);
            if (t >= 4 && t <= 8) chk("bp_ready_low", bus.req0_ready, 0);
            if (t == 9) chk("bp_ready_resume", bus.req0_ready, 1);
            if (bus.req0_valid && bus.req0_ready) sent++;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.out_ready  = 1'b1;
        chk("bp_all_sent", sent, 6);

        // Error bins on req1
        repeat (3) tick();
        bus.req1_valid = 1'b1; bus.req1_bin = 7'd100;
        tick();
        bus.req1_bin = 7'd127;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            if (k <= 2) chk("err_lut_index", bus.lut_index, 0);
            if (k >= 2) begin
                chk("err_flag", bus.out_err, 1);
                chk("err_sin", bus.out_sin, 0);
                chk("err_cos", bus.out_cos, 0);
                chk("err_id", bus.out_id, 1);
            end
            if (k == 1) begin
                tick();
                bus.req1_valid = 1'b0;
            end
        end

        // Reset with two entries in flight
        repeat (3) tick();
        bus.out_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_bin = 7'd40;
        repeat (3) tick();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_ready", bus.req0_ready, 0);
        bus.out_ready  = 1'b1;
        bus.req0_bin   = 7'd7;
        bus.req1_valid = 1'b1; bus.req1_bin = 7'd77;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_grant0", bus.req0_ready, 1);
        chk("post_rst_grant1", bus.req1_ready, 0);
        repeat (4) tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Randomized traffic with occasional resets
        for (int t = 0; t < 3000; t++) begin
            tick();
            bus.req0_valid = ($urandom_range(0, 9) < 7);
            bus.req1_valid = ($urandom_range(0, 9) < 6);
            bus.req0_bin   = 7'($urandom_range(0, 127));
            bus.req1_bin   = 7'($urandom_range(0, 127));
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
        end
        tick();
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
